spi_slave_tx: RTL
=================

// Module: spi_slave_tx
// PURPOSE
//   SPI slave (mode 0, MSB first) that answers our 16-bit SPI master: loads a parallel word,
//   drives it onto MISO while CSbar is low, and captures MOSI into RX_DATA.
//   Stands in for the remote sensor/ADC in loop-back builds, and serves the FPGA-to-FPGA link.
//   SCK/CSbar/MOSI are oversampled on CLK. Fully synchronous to CLK, except the reset.
// PARAMETERS
//   DATA_W      16  frame length in bits (TX and RX)
//   SYNC_STAGES 2   flip-flop stages on SCK, CSbar, MOSI (min 2)
// PORTS
//   CLK       in   1       system clock; must satisfy CLK >= 2*(SYNC_STAGES+2) x SCK
//   RST_n     in   1       asynchronous, active-low reset
//   SCK       in   1       SPI clock from master (asynchronous)
//   CSbar     in   1       SPI chip select, active low (asynchronous)
//   MOSI      in   1       master-out data (asynchronous)
//   MISO      out  1       slave-out data
//   MISO_OE   out  1       1 = drive MISO pad; 0 = tri-state (CSbar high)
//   TX_DATA   in   DATA_W  next word to transmit
//   TX_VALID  in   1       TX_DATA valid; transfer on TX_VALID & TX_READY
//   TX_READY  out  1       holding register empty
//   RX_DATA   out  DATA_W  last complete word received on MOSI
//   RX_VALID  out  1       1-cycle pulse: RX_DATA updated
//   UNDERRUN  out  1       1-cycle pulse: frame started with holding register empty
//   ABORT     out  1       1-cycle pulse: CSbar rose before DATA_W SCK rising edges
// BEHAVIOUR
//   Reset: state IDLE; MISO=0, MISO_OE=0, TX_READY=1, RX_DATA=0; all pulses 0.
//     CSbar synchroniser resets to 1, SCK/MOSI synchronisers reset to 0. Hold/shift regs cleared.
//   Edges: cs_fall, cs_rise, sck_rise, sck_fall are detected on the last sync stage vs its
//     previous value; each is 1 CLK wide. Pin-to-action latency = SYNC_STAGES+1 CLK.
//   Holding reg: write on TX_VALID & TX_READY; TX_READY = ~hold_valid (registered).
//   FSM IDLE:
//     - On cs_fall: shift reg <= hold (hold_valid=1, then clear hold_valid), else <= 0 with UNDERRUN pulse.
//     - bit_cnt <= 0, go to SHIFT.
//     - A TX write in the same cycle as cs_fall is NOT used by this frame; it is kept for the next frame.
//   FSM SHIFT:
//     - MISO_OE=1; MISO = shift[DATA_W-1] (registered).
//     - On sck_rise: rx_sh <= {rx_sh[DATA_W-2:0], MOSI_sync}; bit_cnt++.
//       At bit_cnt == DATA_W-1: RX_DATA <= new word, RX_VALID pulse, go to TAIL.
//     - On sck_fall: shift <= {shift[DATA_W-2:0],1'b0}.
//       A sck_fall is ignored if no sck_rise has occurred yet in this frame.
//   FSM TAIL:
//     - MISO_OE=1; MISO=0. Extra SCK edges are ignored (the master clocks DATA_W+1 edges).
//     - No counter wrap; bit_cnt saturates.
//   CSbar:
//     - cs_rise in any state -> IDLE, MISO_OE=0, MISO=0 on the next CLK.
//     - In SHIFT (bit_cnt < DATA_W): ABORT pulse, no RX_VALID, and the loaded word is discarded (not re-queued).
//   Simultaneous edges in one CLK:
//     - cs_rise has priority over sck edges.
//     - cs_fall with sck_rise: the frame starts and the sck edge is ignored.
//   RST_n low mid-frame: immediate return to reset values; the hold word is lost.
//   Width rule: bit_cnt is $clog2(DATA_W+1) bits.
// TESTING
//   1 Basic frame: TX 16'hA5C3, CSbar low, 16 SCK at CLK/8, MOSI=16'h1234
//     -> MISO bits match A5C3 MSB-first at each SCK rise; RX_DATA=1234; RX_VALID is a single pulse.
//   2 Master timing: 17 SCK edges then CSbar high
//     -> 17th sample is 0, no second RX_VALID, no ABORT, MISO_OE=0 within SYNC_STAGES+2 CLK of CSbar rise.
//   3 Underrun: no TX write, start frame -> UNDERRUN pulse at frame start, MISO all 0; TX_READY stays 1.
//   4 Abort: CSbar high after 7 SCK -> ABORT pulse, RX_VALID never asserted; next frame sends the next queued word.
//   5 Write/CS race: TX_VALID in same CLK as cs_fall with hold empty
//     -> UNDERRUN pulse for this frame; the written word goes out in the next frame; TX_READY=0 until then.
//   6 Reset mid-frame: RST_n low after 5 SCK -> MISO=0, MISO_OE=0, TX_READY=1 at once; a clean frame follows.

Source files
------------

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave, MSB first: parallel word out on MISO, MOSI captured to RX_DATA.
// SCK/CSbar/MOSI are oversampled on CLK; only the reset is asynchronous.
module spi_slave_tx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              SCK,
  input  logic              CSbar,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              UNDERRUN,
  output logic              ABORT
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_q;
  logic                   r_cs_q;

  logic [DATA_W-1:0] r_hold;
  logic              r_hold_valid;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_sh;
  logic [CW-1:0]     r_bit_cnt;

  logic w_sck;
  logic w_cs;
  logic w_mosi;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_rise;
  logic w_cs_fall;

  logic              w_start;
  logic              w_load;
  logic              w_underrun;
  logic              w_abort;
  logic              w_rx_shift;
  logic              w_rx_done;
  logic              w_tx_shift;
  logic              w_wr;
  logic              w_hold_valid_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_rx_word;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sck_rise = w_sck & ~r_sck_q;
  assign w_sck_fall = ~w_sck & r_sck_q;
  assign w_cs_rise  = w_cs & ~r_cs_q;
  assign w_cs_fall  = ~w_cs & r_cs_q;

  assign w_wr      = TX_VALID & TX_READY;
  assign w_rx_word = {r_rx_sh[DATA_W-2:0], w_mosi};

  // Pin synchronisers plus previous-value flops for edge detection
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_q     <= 1'b0;
      r_cs_q      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CSbar};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sck_q     <= w_sck;
      r_cs_q      <= w_cs;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-cycle control; cs_rise outranks any SCK edge
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    w_underrun  = 1'b0;
    w_abort     = 1'b0;
    w_rx_shift  = 1'b0;
    w_rx_done   = 1'b0;
    w_tx_shift  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
          w_load      = r_hold_valid;
          w_underrun  = ~r_hold_valid;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else if (w_sck_rise) begin
          w_rx_shift = 1'b1;
          if (r_bit_cnt == CW'(DATA_W - 1)) begin
            w_rx_done   = 1'b1;
            w_state_nxt = TAIL;
          end
        end else if (w_sck_fall && r_bit_cnt != '0) begin
          w_tx_shift = 1'b1;
        end
      end
      TAIL: begin
        if (w_cs_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next holding-register flag and TX shift contents
  always_comb begin
    w_hold_valid_nxt = r_hold_valid;
    if (w_wr)        w_hold_valid_nxt = 1'b1;
    else if (w_load) w_hold_valid_nxt = 1'b0;
    w_shift_nxt = r_shift;
    if (w_start)
      w_shift_nxt = w_load ? r_hold : '0;
    else if (w_state_nxt == IDLE)
      w_shift_nxt = '0;
    else if (w_tx_shift)
      w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
  end

  // Holding register, shift registers, bit counter
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_rx_sh      <= '0;
      r_bit_cnt    <= '0;
    end else begin
      if (w_wr) r_hold <= TX_DATA;
      r_hold_valid <= w_hold_valid_nxt;
      r_shift      <= w_shift_nxt;
      if (w_start) begin
        r_rx_sh   <= '0;
        r_bit_cnt <= '0;
      end else if (w_rx_shift) begin
        r_rx_sh   <= w_rx_word;
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Registered outputs and single-cycle status pulses
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      MISO     <= 1'b0;
      MISO_OE  <= 1'b0;
      TX_READY <= 1'b1;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      UNDERRUN <= 1'b0;
      ABORT    <= 1'b0;
    end else begin
      MISO     <= (w_state_nxt == SHIFT) ? w_shift_nxt[DATA_W-1] : 1'b0;
      MISO_OE  <= (w_state_nxt != IDLE);
      TX_READY <= ~w_hold_valid_nxt;
      if (w_rx_done) RX_DATA <= w_rx_word;
      RX_VALID <= w_rx_done;
      UNDERRUN <= w_underrun;
      ABORT    <= w_abort;
    end
  end

endmodule
